fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch initiator for the 8-bit SimpleCPU; drives the byte address into the instruction memory and captures the 16-bit instruction it returns combinationally.
- Holds the program counter (PC) and presents one registered instruction at a time to decode through a valid/ready handshake.
- Handles redirects from execute: branch (br/brz/brn), call (br.sub) and return. Call and return use an internal return-address stack.

Parameters:
- RAS_DEPTH, 4, number of return-address stack entries (power of two, 2..16).
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  fetch enable; when low, no new fetches, output register holds.
- imem_addr  out  8  byte address to instruction memory; always equals PC.
- imem_ins  in  16  instruction from memory: {mem[addr+1], mem[addr]}, combinational.
- if_valid  out  1  output instruction valid.
- if_ins  out  16  registered instruction.
- if_pc  out  8  address of if_ins.
- if_ready  in  1  decode accepts if_ins this cycle.
- redir_valid  in  1  redirect request from execute, single-cycle pulse.
- redir_kind  in  2  00 jump, 01 call, 10 return, 11 reserved (treated as jump).
- redir_target  in  8  target address for jump and call.
- redir_link  in  8  return address pushed on call.
- ras_overflow  out  1  sticky; set when a push hits a full stack.
- ras_underflow  out  1  sticky; set when a pop hits an empty stack.
- misalign  out  1  sticky; set when a jump/call target has bit0 = 1.

Behaviour:
- Reset, sampled on clk rising edge:
  - PC = RESET_PC, if_valid = 0, if_ins = 16'h0000, if_pc = 8'h00.
  - Stack empty; all sticky flags 0; FSM = IDLE.
  - Reset wins over every other input, including an in-flight redirect.
- FSM states:
  - IDLE: after reset. Goes to RUN on the first cycle with run = 1. No fetch occurs in that transition cycle.
  - RUN: normal fetch.
  - PAUSE: entered from RUN when run = 0; returns to RUN when run = 1.
  - In PAUSE, redirects are still accepted (PC, stack and flush update); only the advance is suppressed.
- Advance condition, RUN only: run = 1 and (if_valid = 0 or if_ready = 1) and redir_valid = 0. On advance:
  - if_ins <= imem_ins, if_pc <= PC, if_valid <= 1.
  - PC <= PC + 2, modulo 256, so 8'hFE wraps to 8'h00.
- Latency: PC to if_valid is 1 cycle. Sustained throughput is 1 instruction per cycle while if_ready = 1.
- Stall: if_valid = 1 and if_ready = 0 holds if_ins, if_pc and PC unchanged.
- Handshake rule: once if_valid = 1, if_ins and if_pc may not change until accepted or flushed.
- Accept with nothing new: if_ready = 1 without an advance (run = 0, or PAUSE) clears if_valid next cycle.
- Redirect (redir_valid = 1), in any state except IDLE:
  - if_valid <= 0 (flush), regardless of if_ready.
  - Jump: PC <= {redir_target[7:1], 1'b0}.
  - Call: push redir_link, then PC <= aligned target.
  - Return: pop top of stack into PC. If empty: PC <= RESET_PC and set ras_underflow.
  - misalign is set when a jump/call target has bit0 = 1.
  - Cost: exactly one bubble cycle; the fetch at the new PC appears on if_ins 2 cycles after the redirect pulse.
- Stack behaviour:
  - Circular LIFO with a count register, range 0..RAS_DEPTH.
  - Push when full overwrites the oldest entry, count stays RAS_DEPTH, and ras_overflow is set.
  - Pop decrements count.
- Sticky flags clear only on rst.

Decomposition:
- Shared package fetch_pkg:
  - Redirect kind constants: RK_JUMP = 2'b00, RK_CALL = 2'b01, RK_RET = 2'b10.
  - FSM state encoding: IDLE, RUN, PAUSE.
  - Constant INS_BYTES = 2.
- One natural sub-module: ras_stack (clk, rst, push, pop, din, dout, empty, full, overflow, underflow), parameterised by RAS_DEPTH.

Test Plan:
- Reset then run = 1, if_ready = 1, memory holding NOPs → IDLE→RUN; if_pc sequence 00, 02, 04, 06 on consecutive cycles; imem_addr leads if_pc by 1 cycle.
- Hold if_ready = 0 for 3 cycles at if_pc = 04 → if_ins and if_pc stable for 3 cycles; PC stays 06; resumes with 06 once if_ready = 1.
- Jump to 8'h24 while if_pc = 1E valid → next cycle if_valid = 0; following cycle if_pc = 24 with if_ins = mem{25,24}.
- Call target 8'h34, link 8'h2A, then return → after call, fetch at 34; after return, fetch at 2A; stack empty; no flags set.
- 5 calls with RAS_DEPTH = 4 (links 10, 12, 14, 16, 18), then 5 returns → ras_overflow = 1; returns yield 18, 16, 14, 12; 5th return gives PC = 00 and ras_underflow = 1.
- PC = FE advancing → if_pc = FE then 00 (wrap); jump target 8'h25 → fetch at 24, misalign = 1; rst mid-stall → if_valid = 0, PC = 00, flags cleared.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the SimpleCPU instruction-fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    RK_JUMP = 2'b00,
    RK_CALL = 2'b01,
    RK_RET  = 2'b10,
    RK_RSVD = 2'b11
  } redir_kind_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } fetch_state_e;

  localparam logic [7:0] INS_BYTES = 8'd2;

  // Instructions are two bytes wide, so every fetch address is even.
  function automatic logic [7:0] align_pc(input logic [7:0] addr);
    return {addr[7:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory, decode-handshake and execute-redirect signals of the fetch unit.
interface fetch_unit_if;
  logic [7:0]  imem_addr;
  logic [15:0] imem_ins;
  logic        if_valid;
  logic [15:0] if_ins;
  logic [7:0]  if_pc;
  logic        if_ready;
  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic [7:0]  redir_target;
  logic [7:0]  redir_link;

  modport master (
    output imem_addr, if_valid, if_ins, if_pc,
    input  imem_ins, if_ready, redir_valid, redir_kind, redir_target, redir_link
  );

  modport slave (
    input  imem_addr, if_valid, if_ins, if_pc,
    output imem_ins, if_ready, redir_valid, redir_kind, redir_target, redir_link
  );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// an empty pop leaves the stack untouched; both raise sticky flags.
module ras_stack #(
  parameter int RAS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       underflow
);
  localparam int PW = $clog2(RAS_DEPTH);

  logic [7:0]    r_mem [RAS_DEPTH];
  logic [PW-1:0] r_top;
  logic [PW-1:0] w_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;
  logic          r_underflow;

  // r_top is the next write slot; a power-of-two depth makes the wrap free.
  assign w_rd_ptr  = r_top - PW'(1);
  assign dout      = r_mem[w_rd_ptr];
  assign empty     = (r_count == '0);
  assign full      = (r_count == (PW+1)'(RAS_DEPTH));
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // NOTE: storage is not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_top] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_top       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (push) begin
      r_top <= r_top + PW'(1);
      if (full) r_overflow <= 1'b1;
      else      r_count    <= r_count + (PW+1)'(1);
    end else if (pop) begin
      if (empty) begin
        r_underflow <= 1'b1;
      end else begin
        r_top   <= w_rd_ptr;
        r_count <= r_count - (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, registers one instruction for decode
// behind a valid/ready handshake, and follows jump/call/return redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int         RAS_DEPTH = 4,
  parameter logic [7:0] RESET_PC  = 8'h00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  fetch_unit_if.master bus,
  output logic         ras_overflow,
  output logic         ras_underflow,
  output logic         misalign
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [7:0]   r_pc;
  logic [7:0]   w_pc_next;
  logic         r_if_valid;
  logic [15:0]  r_if_ins;
  logic [7:0]   r_if_pc;
  logic         r_misalign;
  redir_kind_e  w_kind;
  logic         w_redir;
  logic         w_advance;
  logic         w_push;
  logic         w_pop;
  logic         w_misalign_set;
  logic [7:0]   w_ras_top;
  logic         w_ras_empty;
  logic         w_ras_full;

  assign w_kind        = redir_kind_e'(bus.redir_kind);
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_ins    = r_if_ins;
  assign bus.if_pc     = r_if_pc;
  assign misalign      = r_misalign;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next   = r_state;
    w_redir        = 1'b0;
    w_advance      = 1'b0;
    w_push         = 1'b0;
    w_pop          = 1'b0;
    w_misalign_set = 1'b0;
    w_pc_next      = r_pc;

    case (r_state)
      IDLE: if (run) w_state_next = RUN;
      RUN: begin
        if (!run) w_state_next = PAUSE;
        w_redir   = bus.redir_valid;
        w_advance = run && (!r_if_valid || bus.if_ready) && !bus.redir_valid;
      end
      PAUSE: begin
        if (run) w_state_next = RUN;
        w_redir = bus.redir_valid;
      end
      default: w_state_next = IDLE;
    endcase

    // Reserved redirect kind falls through to the jump behaviour.
    if (w_redir) begin
      case (w_kind)
        RK_RET: begin
          w_pop     = 1'b1;
          w_pc_next = w_ras_empty ? RESET_PC : w_ras_top;
        end
        RK_CALL: begin
          w_push         = 1'b1;
          w_misalign_set = bus.redir_target[0];
          w_pc_next      = align_pc(bus.redir_target);
        end
        default: begin
          w_misalign_set = bus.redir_target[0];
          w_pc_next      = align_pc(bus.redir_target);
        end
      endcase
    end else if (w_advance) begin
      w_pc_next = r_pc + INS_BYTES;
    end
  end

  // NOTE: registers use non-blocking assignments so all state updates at the same edge.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_ins   <= 16'h0000;
      r_if_pc    <= 8'h00;
      r_misalign <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_misalign_set) r_misalign <= 1'b1;
      if (w_redir) begin
        r_if_valid <= 1'b0;
      end else if (w_advance) begin
        r_if_ins   <= bus.imem_ins;
        r_if_pc    <= r_pc;
        r_if_valid <= 1'b1;
      end else if (bus.if_ready) begin
        r_if_valid <= 1'b0;
      end
    end
  end

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .din       (bus.redir_link),
    .dout      (w_ras_top),
    .empty     (w_ras_empty),
    .full      (w_ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit, checked every cycle against
// a transaction-level model of PC, output register and return stack.
module tb_fetch_unit;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RPC   = 8'h00;

  logic clk = 1'b0;
  logic rst;
  logic run;
  logic ras_overflow;
  logic ras_underflow;
  logic misalign;

  fetch_unit_if bus();

  logic [7:0] mem [256];
  assign bus.imem_ins = {mem[bus.imem_addr + 8'd1], mem[bus.imem_addr]};

  fetch_unit #(
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (RPC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .bus           (bus),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [15:0] m_ins;
  logic [7:0]  m_ipc;
  logic [7:0]  m_ras [$];
  logic        m_ovf, m_unf, m_mis;
  logic        m_started;  // run has been seen since reset
  logic        m_run_d;    // run as sampled at the previous edge: fetching is live

  logic [7:0] exp_ret [5];

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    logic [7:0] b;
    b = a + 8'd1;
    return {mem[b], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic redir;
    logic adv;
    if (rst) begin
      m_pc = RPC; m_valid = 1'b0; m_ins = 16'h0000; m_ipc = 8'h00;
      m_ras.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_mis = 1'b0;
      m_started = 1'b0; m_run_d = 1'b0;
    end else begin
      redir = bus.redir_valid && m_started;
      adv   = m_run_d && run && (!m_valid || bus.if_ready) && !bus.redir_valid;
      if (redir) begin
        m_valid = 1'b0;
        if (bus.redir_kind == 2'b10) begin
          if (m_ras.size() == 0) begin
            m_pc  = RPC;
            m_unf = 1'b1;
          end else begin
            m_pc = m_ras.pop_back();
          end
        end else begin
          if (bus.redir_kind == 2'b01) begin
            if (m_ras.size() == DEPTH) begin
              void'(m_ras.pop_front());
              m_ovf = 1'b1;
            end
            m_ras.push_back(bus.redir_link);
          end
          if (bus.redir_target[0]) m_mis = 1'b1;
          m_pc = bus.redir_target & 8'hFE;
        end
      end else if (adv) begin
        m_ins   = mem_word(m_pc);
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 8'd2;
      end else if (bus.if_ready) begin
        m_valid = 1'b0;
      end
      m_started = m_started || run;
      m_run_d   = run;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("if_valid", bus.if_valid, m_valid);
    check("if_ins", bus.if_ins, m_ins);
    check("if_pc", bus.if_pc, m_ipc);
    check("imem_addr", bus.imem_addr, m_pc);
    check("ras_overflow", ras_overflow, m_ovf);
    check("ras_underflow", ras_underflow, m_unf);
    check("misalign", misalign, m_mis);
  endtask

  task automatic redirect(input logic [1:0] kind, input logic [7:0] target, input logic [7:0] link);
    bus.redir_valid  = 1'b1;
    bus.redir_kind   = kind;
    bus.redir_target = target;
    bus.redir_link   = link;
    tick();
    bus.redir_valid  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    exp_ret[0] = 8'h18; exp_ret[1] = 8'h16; exp_ret[2] = 8'h14;
    exp_ret[3] = 8'h12; exp_ret[4] = 8'h00;

    rst = 1'b1; run = 1'b0;
    bus.if_ready = 1'b0; bus.redir_valid = 1'b0; bus.redir_kind = 2'b00;
    bus.redir_target = 8'h00; bus.redir_link = 8'h00;
    tick(); tick();
    check("rst_valid", bus.if_valid, 1'b0);
    check("rst_ins", bus.if_ins, 16'h0000);
    check("rst_pc", bus.imem_addr, 8'h00);

    // IDLE -> RUN takes a cycle without fetching, then one instruction per cycle
    rst = 1'b0; run = 1'b1; bus.if_ready = 1'b1;
    tick();
    check("idle_no_fetch", bus.if_valid, 1'b0);
    tick();
    check("first_pc", bus.if_pc, 8'h00);
    check("addr_leads", bus.imem_addr, 8'h02);
    tick();
    check("second_pc", bus.if_pc, 8'h02);
    tick();
    check("third_pc", bus.if_pc, 8'h04);

    // Decode stall holds the output register and PC
    bus.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.if_pc, 8'h04);
      check("stall_ins", bus.if_ins, mem_word(8'h04));
      check("stall_addr", bus.imem_addr, 8'h06);
    end
    bus.if_ready = 1'b1;
    tick();
    check("resume_pc", bus.if_pc, 8'h06);

    // Jump taken while 1E is presented
    for (int i = 0; i < 40 && !(m_valid && m_ipc == 8'h1E); i++) tick();
    check("reach_1e", bus.if_pc, 8'h1E);
    redirect(2'b00, 8'h24, 8'h00);
    check("jump_flush", bus.if_valid, 1'b0);
    tick();
    check("jump_pc", bus.if_pc, 8'h24);
    check("jump_ins", bus.if_ins, mem_word(8'h24));

    // Call then return
    redirect(2'b01, 8'h34, 8'h2A);
    tick();
    check("call_pc", bus.if_pc, 8'h34);
    tick(); tick();
    redirect(2'b10, 8'h00, 8'h00);
    tick();
    check("ret_pc", bus.if_pc, 8'h2A);
    check("ret_flags", {ras_overflow, ras_underflow, misalign}, 3'b000);

    // Five calls into a four-deep stack, then five returns
    for (int i = 0; i < 5; i++) begin
      redirect(2'b01, 8'(8'h60 + 4 * i), 8'(8'h10 + 2 * i));
      tick();
    end
    check("ovf_set", ras_overflow, 1'b1);
    for (int i = 0; i < 5; i++) begin
      redirect(2'b10, 8'h00, 8'h00);
      tick();
      check("ret_seq", bus.if_pc, exp_ret[i]);
    end
    check("unf_set", ras_underflow, 1'b1);

    // PC wrap and misaligned target
    redirect(2'b00, 8'hFC, 8'h00);
    tick();
    check("wrap_fc", bus.if_pc, 8'hFC);
    tick();
    check("wrap_fe", bus.if_pc, 8'hFE);
    tick();
    check("wrap_00", bus.if_pc, 8'h00);
    redirect(2'b00, 8'h25, 8'h00);
    check("mis_set", misalign, 1'b1);
    tick();
    check("mis_pc", bus.if_pc, 8'h24);

    // Randomized traffic including pauses and redirects while paused
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      run          = ($urandom_range(0, 9) != 0);
      bus.if_ready = ($urandom_range(0, 3) != 0);
      if (!bus.redir_valid && $urandom_range(0, 6) == 0) begin
        bus.redir_valid  = 1'b1;
        bus.redir_kind   = 2'($urandom_range(0, 3));
        bus.redir_target = 8'($urandom);
        bus.redir_link   = 8'($urandom);
      end else begin
        bus.redir_valid = 1'b0;
      end
      tick();
    end
    bus.redir_valid = 1'b0;

    // Reset during a stall, with a redirect pending, then a redirect in IDLE
    run = 1'b1; bus.if_ready = 1'b0;
    tick(); tick(); tick();
    check("prestall_valid", bus.if_valid, 1'b1);
    rst = 1'b1;
    bus.redir_valid = 1'b1; bus.redir_kind = 2'b01; bus.redir_target = 8'h41;
    tick();
    check("rst_mid_valid", bus.if_valid, 1'b0);
    check("rst_mid_pc", bus.imem_addr, 8'h00);
    check("rst_mid_flags", {ras_overflow, ras_underflow, misalign}, 3'b000);
    rst = 1'b0; run = 1'b0;
    bus.redir_kind = 2'b00; bus.redir_target = 8'h40;
    tick();
    check("idle_ignores_redir", bus.imem_addr, 8'h00);
    bus.redir_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
